passcode_checker: RTL and testbench

- Consumer of the 2-bit switch-state code from the input-state block. The two switches form one "digit" (0-3), and an Enter button commits it.
- Collects CODE_LEN committed digits, compares the whole sequence against a stored passcode, and drives unlock, error and alarm indications.
- Sits between the switch-state decoder and the front-panel LEDs/alarm of the security system.

---
 rtl/passcode_checker_if.sv | 21 ++
 rtl/passcode_checker.sv | 114 +++++++++++
 tb/tb_passcode_checker.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/passcode_checker_if.sv
// Switch-digit / Enter inputs and lock-status outputs of the passcode checker.
// The master drives the digit and Enter button; the slave is the checker itself.
interface passcode_checker_if;
    logic [1:0] i_input_states;
    logic       i_Enter;
    logic       o_unlocked;
    logic       o_error;
    logic       o_alarm;
    logic [2:0] o_digit_count;
    logic [2:0] o_fail_count;

    modport master (
        output i_input_states, i_Enter,
        input  o_unlocked, o_error, o_alarm, o_digit_count, o_fail_count
    );

    modport slave (
        input  i_input_states, i_Enter,
        output o_unlocked, o_error, o_alarm, o_digit_count, o_fail_count
    );
endinterface

// File: rtl/passcode_checker.sv
// Collects CODE_LEN two-bit digits on Enter edges, compares them with PASSCODE and
// drives unlock / timed error / latched alarm indications.
module passcode_checker #(
    parameter int                    CODE_LEN   = 4,
    parameter logic [2*CODE_LEN-1:0] PASSCODE   = 8'b00_11_01_10,
    parameter int                    MAX_FAILS  = 3,
    parameter int                    ERR_CYCLES = 16
) (
    input  logic                i_Clk,
    input  logic                i_Reset,
    passcode_checker_if.slave   bus
);

    localparam int TIMER_W = (ERR_CYCLES > 1) ? $clog2(ERR_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_CHECK,
        S_UNLOCKED,
        S_ERROR,
        S_ALARM
    } state_e;

    state_e                 state_q, state_d;
    logic                   enter_prev_q, enter_prev_d;
    logic [2*CODE_LEN-1:0]  code_buf_q, code_buf_d;
    logic [2:0]             digit_count_q, digit_count_d;
    logic [2:0]             fail_count_q, fail_count_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic                   enter_edge;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d       = state_q;
        enter_prev_d  = bus.i_Enter;
        code_buf_d    = code_buf_q;
        digit_count_d = digit_count_q;
        fail_count_d  = fail_count_q;
        timer_d       = timer_q;
        enter_edge    = bus.i_Enter & ~enter_prev_q;

        case (state_q)
            S_IDLE: begin
                if (enter_edge) begin
                    code_buf_d[1:0] = bus.i_input_states;
                    digit_count_d   = 3'd1;
                    state_d         = (CODE_LEN == 1) ? S_CHECK : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (enter_edge) begin
                    for (int i = 0; i < CODE_LEN; i++) begin
                        if (digit_count_q == 3'(i)) code_buf_d[2*i +: 2] = bus.i_input_states;
                    end
                    digit_count_d = digit_count_q + 3'd1;
                    if (digit_count_q == 3'(CODE_LEN - 1)) state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                digit_count_d = 3'd0;
                if (code_buf_q == PASSCODE) begin
                    state_d      = S_UNLOCKED;
                    fail_count_d = 3'd0;
                end else if (fail_count_q + 3'd1 == 3'(MAX_FAILS)) begin
                    state_d      = S_ALARM;
                    fail_count_d = 3'(MAX_FAILS);
                end else begin
                    state_d      = S_ERROR;
                    fail_count_d = fail_count_q + 3'd1;
                    timer_d      = TIMER_W'(ERR_CYCLES - 1);
                end
            end
            S_UNLOCKED: begin
                // Relock only; the digit for the next attempt needs a fresh edge in IDLE.
                if (enter_edge) state_d = S_IDLE;
            end
            S_ERROR: begin
                if (timer_q == '0) state_d = S_IDLE;
                else               timer_d = timer_q - 1'b1;
            end
            S_ALARM: state_d = S_ALARM;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q       <= S_IDLE;
            // Held-through-reset button must not count as a press.
            enter_prev_q  <= 1'b1;
            // NOTE: the digit buffer is reset too, so a compare never sees X after power-up.
            code_buf_q    <= '0;
            digit_count_q <= 3'd0;
            fail_count_q  <= 3'd0;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            enter_prev_q  <= enter_prev_d;
            code_buf_q    <= code_buf_d;
            digit_count_q <= digit_count_d;
            fail_count_q  <= fail_count_d;
            timer_q       <= timer_d;
        end
    end

    assign bus.o_unlocked    = (state_q == S_UNLOCKED);
    assign bus.o_error       = (state_q == S_ERROR);
    assign bus.o_alarm       = (state_q == S_ALARM);
    assign bus.o_digit_count = digit_count_q;
    assign bus.o_fail_count  = fail_count_q;

endmodule

// File: tb/tb_passcode_checker.sv
// Directed bench for passcode_checker: correct/wrong codes, error timing, alarm latch,
// fail-count clearing, held button and reset corner cases.
module tb_passcode_checker;

    logic i_Clk;
    logic i_Reset;
    int   total;
    int   bad;

    passcode_checker_if pc_if ();

    passcode_checker #(
        .CODE_LEN   (4),
        .PASSCODE   (8'b00_11_01_10),
        .MAX_FAILS  (3),
        .ERR_CYCLES (16)
    ) dut (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .bus     (pc_if.slave)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge i_Clk);
    endtask

    // One-cycle Enter pulse; returns just after the edge has been sampled.
    task automatic press(input logic [1:0] d);
        pc_if.i_input_states = d;
        pc_if.i_Enter        = 1'b1;
        step(1);
        pc_if.i_Enter        = 1'b0;
    endtask

    // Returns with the DUT in CHECK (one cycle after the final digit's edge).
    task automatic enter_code(input logic [1:0] d0, input logic [1:0] d1,
                              input logic [1:0] d2, input logic [1:0] d3);
        press(d0); step(1);
        press(d1); step(1);
        press(d2); step(1);
        press(d3);
    endtask

    task automatic do_reset();
        i_Reset = 1'b1;
        step(2);
        i_Reset = 1'b0;
        step(1);
    endtask

    int err_hi;

    initial begin
        total = 0;
        bad   = 0;
        i_Reset              = 1'b1;
        pc_if.i_Enter        = 1'b0;
        pc_if.i_input_states = 2'd0;
        step(2);
        i_Reset = 1'b0;
        step(1);

        // Reset state
        check("rst_unlocked", pc_if.o_unlocked,    0);
        check("rst_error",    pc_if.o_error,       0);
        check("rst_alarm",    pc_if.o_alarm,       0);
        check("rst_digits",   pc_if.o_digit_count, 0);
        check("rst_fails",    pc_if.o_fail_count,  0);

        // Correct code 2,1,3,0
        press(2'd2); check("ok_cnt1", pc_if.o_digit_count, 1); step(1);
        press(2'd1); check("ok_cnt2", pc_if.o_digit_count, 2); step(1);
        press(2'd3); check("ok_cnt3", pc_if.o_digit_count, 3); step(1);
        press(2'd0); check("ok_cnt4", pc_if.o_digit_count, 4);
        check("ok_not_yet", pc_if.o_unlocked, 0);
        step(1);
        check("ok_unlocked", pc_if.o_unlocked,    1);
        check("ok_fails0",   pc_if.o_fail_count,  0);
        check("ok_cnt_clr",  pc_if.o_digit_count, 0);
        press(2'd2);
        check("relock",      pc_if.o_unlocked,    0);
        check("relock_cnt",  pc_if.o_digit_count, 0);
        step(1);
        check("relock_nocap", pc_if.o_digit_count, 0);

        // Wrong code 2,1,3,1: error held for 16 cycles, Enter ignored meanwhile
        enter_code(2'd2, 2'd1, 2'd3, 2'd1);
        err_hi = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (pc_if.o_error === 1'b1) err_hi++;
            if (i == 0) check("err_fails1", pc_if.o_fail_count, 1);
            if (i == 10) check("err_ignore_enter", pc_if.o_digit_count, 0);
            pc_if.i_Enter = (i == 1 || i == 5 || i == 9);
        end
        check("err_cycles",   8'(err_hi),            16);
        check("err_done",     pc_if.o_error,         0);
        check("err_idle_cnt", pc_if.o_digit_count,   0);
        check("err_fails_kept", pc_if.o_fail_count,  1);

        // Alarm after three consecutive wrong codes
        do_reset();
        enter_code(2'd0, 2'd0, 2'd0, 2'd0); step(1);
        check("al_fail1", pc_if.o_fail_count, 1);
        step(16);
        enter_code(2'd3, 2'd3, 2'd3, 2'd3); step(1);
        check("al_fail2", pc_if.o_fail_count, 2);
        check("al_err2",  pc_if.o_error,      1);
        step(16);
        enter_code(2'd1, 2'd1, 2'd1, 2'd1); step(1);
        check("al_alarm", pc_if.o_alarm,      1);
        check("al_fail3", pc_if.o_fail_count, 3);
        check("al_noerr", pc_if.o_error,      0);
        press(2'd1); step(1);
        enter_code(2'd2, 2'd1, 2'd3, 2'd0); step(2);
        check("al_latched", pc_if.o_alarm,       1);
        check("al_locked",  pc_if.o_unlocked,    0);
        check("al_nocap",   pc_if.o_digit_count, 0);
        check("al_fail3b",  pc_if.o_fail_count,  3);
        do_reset();
        check("al_rst_alarm", pc_if.o_alarm,      0);
        check("al_rst_fails", pc_if.o_fail_count, 0);
        check("al_rst_unl",   pc_if.o_unlocked,   0);
        check("al_rst_err",   pc_if.o_error,      0);

        // Fail counter cleared by a correct code
        enter_code(2'd2, 2'd1, 2'd3, 2'd1); step(1);
        check("fc_fail1", pc_if.o_fail_count, 1);
        step(16);
        enter_code(2'd2, 2'd1, 2'd3, 2'd0); step(1);
        check("fc_unlock", pc_if.o_unlocked,   1);
        check("fc_fail0",  pc_if.o_fail_count, 0);
        press(2'd0); step(1);
        enter_code(2'd1, 2'd1, 2'd1, 2'd1); step(1);
        check("fc_w1_fails", pc_if.o_fail_count, 1);
        step(16);
        enter_code(2'd1, 2'd2, 2'd1, 2'd2); step(1);
        check("fc_w2_fails", pc_if.o_fail_count, 2);
        check("fc_w2_noalarm", pc_if.o_alarm,    0);
        check("fc_w2_err",   pc_if.o_error,      1);
        step(16);
        check("fc_idle", pc_if.o_error, 0);

        // Held button yields one digit
        do_reset();
        pc_if.i_input_states = 2'd2;
        pc_if.i_Enter        = 1'b1;
        step(20);
        check("held_one", pc_if.o_digit_count, 1);
        pc_if.i_Enter = 1'b0;
        step(1);
        check("held_release", pc_if.o_digit_count, 1);

        // Enter high during and after reset
        pc_if.i_Enter = 1'b1;
        i_Reset       = 1'b1;
        step(2);
        i_Reset = 1'b0;
        step(3);
        check("rst_held_nocap", pc_if.o_digit_count, 0);
        pc_if.i_Enter = 1'b0;
        step(1);
        check("rst_release_nocap", pc_if.o_digit_count, 0);
        press(2'd3);
        check("rst_repress_cap", pc_if.o_digit_count, 1);

        // Reset mid-entry discards partial code
        do_reset();
        press(2'd2); step(1);
        press(2'd1);
        check("mid_cnt2", pc_if.o_digit_count, 2);
        do_reset();
        check("mid_cnt0", pc_if.o_digit_count, 0);
        enter_code(2'd2, 2'd1, 2'd3, 2'd0); step(1);
        check("mid_unlock", pc_if.o_unlocked, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
